// File: rtl/chu_adsr_core.sv
// ADSR envelope generator slot core: MMIO parameter registers and a
// 32-bit envelope FSM. Optional bypass enabled by ADSR_BYPASS_EN.
module chu_adsr_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [15:0] adsr_env,
  output logic        adsr_idle
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam logic [31:0] MAX = 32'h8000_0000;

  localparam logic [4:0] A_ATK  = 5'd0;
  localparam logic [4:0] A_DCY  = 5'd1;
  localparam logic [4:0] A_SUSL = 5'd2;
  localparam logic [4:0] A_SUST = 5'd3;
  localparam logic [4:0] A_REL  = 5'd4;
  localparam logic [4:0] A_CTRL = 5'd5;

  logic [31:0] atk_step;
  logic [31:0] dcy_step;
  logic [31:0] sus_level;
  logic [31:0] sus_time;
  logic [31:0] rel_step;

  logic [2:0]  state_r;
  logic [2:0]  state_n;
  logic [31:0] env_r;
  logic [31:0] env_n;
  logic [31:0] cnt_r;
  logic [31:0] cnt_n;

  logic        wr_en;
  logic        wr_ctrl;
  logic        start;
  logic        bypass;

  logic [32:0] atk_sum;
  logic [32:0] dcy_diff;
  logic [31:0] sus_clamp;
  logic [31:0] sus_limit;
  logic        atk_done;
  logic        dcy_done;
  logic        sus_done;
  logic        rel_done;

  // read strobe has no effect: reads are side-effect free
  logic unused_read;
  assign unused_read = &{1'b0, read};

  assign wr_en   = cs & write;
  assign wr_ctrl = wr_en && (addr == A_CTRL);

`ifdef ADSR_BYPASS_EN
  logic bypass_r;

  // bypass flag lives in CTRL bit1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bypass_r <= 1'b0;
    end else if (wr_ctrl) begin
      bypass_r <= wr_data[1];
    end
  end

  assign bypass = bypass_r;
`else
  assign bypass = 1'b0;
`endif

  // start is a pulse decoded from CTRL bit0; ignored while bypassed
  assign start = wr_ctrl & wr_data[0] & ~bypass;

  // parameter registers, writable at any time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      atk_step  <= '0;
      dcy_step  <= '0;
      sus_level <= '0;
      sus_time  <= '0;
      rel_step  <= '0;
    end else if (wr_en) begin
      case (addr)
        A_ATK:   atk_step  <= wr_data;
        A_DCY:   dcy_step  <= wr_data;
        A_SUSL:  sus_level <= wr_data;
        A_SUST:  sus_time  <= wr_data;
        A_REL:   rel_step  <= wr_data;
        default: ;
      endcase
    end
  end

  assign atk_sum   = {1'b0, env_r} + {1'b0, atk_step};
  assign dcy_diff  = {1'b0, env_r} - {1'b0, dcy_step};
  assign sus_clamp = (sus_level > MAX) ? MAX : sus_level;
  assign sus_limit = (sus_time == 32'd0) ? 32'd1 : sus_time;

  assign atk_done = (atk_sum >= {1'b0, MAX}) || (atk_step == 32'd0);
  assign dcy_done = dcy_diff[32] ||
                    (dcy_diff[31:0] <= sus_clamp) ||
                    (dcy_step == 32'd0);
  assign sus_done = (cnt_r >= (sus_limit - 32'd1));
  assign rel_done = (env_r <= rel_step) || (rel_step == 32'd0);

  // next-state and envelope arithmetic, one transition per clock
  always_comb begin
    state_n = state_r;
    env_n   = env_r;
    cnt_n   = cnt_r;
    if (bypass) begin
      state_n = IDLE;
      env_n   = '0;
      cnt_n   = '0;
    end else if (start) begin
      state_n = ATTACK;
    end else begin
      case (state_r)
        IDLE: begin
          state_n = IDLE;
        end
        ATTACK: begin
          if (atk_done) begin
            env_n   = MAX;
            state_n = DECAY;
          end else begin
            env_n = atk_sum[31:0];
          end
        end
        DECAY: begin
          if (dcy_done) begin
            env_n   = sus_clamp;
            state_n = SUSTAIN;
            cnt_n   = '0;
          end else begin
            env_n = dcy_diff[31:0];
          end
        end
        SUSTAIN: begin
          if (sus_done) begin
            state_n = RELEASE;
          end else begin
            cnt_n = cnt_r + 32'd1;
          end
        end
        RELEASE: begin
          if (rel_done) begin
            env_n   = '0;
            state_n = IDLE;
          end else begin
            env_n = env_r - rel_step;
          end
        end
        default: begin
          state_n = IDLE;
          env_n   = '0;
        end
      endcase
    end
  end

  // FSM, envelope and sustain counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      env_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      env_r   <= env_n;
      cnt_r   <= cnt_n;
    end
  end

  assign adsr_idle = (state_r == IDLE);
  assign adsr_env  = bypass ? 16'h8000 : env_r[31:16];
  assign rd_data   = {15'b0, adsr_idle, adsr_env};

endmodule
